// File: rtl/tt_um_pwm_capture.sv
`default_nettype none
// ==== tt_um_pwm_capture : PWM high-time / period capture (optional PWM_CAP_FILTER_EN glitch filter)
// ==== Rev 1.0
module tt_um_pwm_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic       sync1_q, sync2_q, prev_q;
  logic       pwm_s, rise, sel, clr;
  state_t     state_q, state_d;
  logic [7:0] period_cnt_q, period_cnt_d;
  logic [7:0] high_cnt_q, high_cnt_d;
  logic [7:0] period_q, period_d;
  logic [7:0] high_q, high_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic       unused;

  assign sel    = ui_in[1];
  assign clr    = ui_in[2];
  assign unused = ^{ui_in[7:3], uio_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ui_in[0];
      sync2_q <= sync1_q;
      prev_q  <= pwm_s;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  logic hist1_q, hist2_q, filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= pwm_s;
    end
  end

  // Three equal samples pass straight through, so a settled level is seen without waiting for filt_q.
  assign pwm_s = ((sync2_q == hist1_q) && (hist1_q == hist2_q)) ? sync2_q : filt_q;
`else
  assign pwm_s = sync2_q;
`endif

  assign rise = pwm_s & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      period_cnt_q <= 8'd0;
      high_cnt_q   <= 8'd0;
      period_q     <= 8'd0;
      high_q       <= 8'd0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = valid_q;
    timeout_d    = timeout_q;
    if (clr) begin
      state_d   = IDLE;
      period_d  = 8'd0;
      high_d    = 8'd0;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
    end else if (!ena) begin
      state_d = IDLE;
    end else if (rise) begin
      state_d      = HIGH;
      period_cnt_d = 8'd1;
      high_cnt_d   = 8'd1;
      // A rise out of IDLE only opens a measurement window.
      if (state_q != IDLE) begin
        period_d  = period_cnt_q;
        high_d    = high_cnt_q;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end
    end else begin
      case (state_q)
        HIGH, LOW: begin
          if (period_cnt_q == 8'hFF) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt_q + 8'd1;
            if (state_q == HIGH) begin
              if (pwm_s) high_cnt_d = high_cnt_q + 8'd1;
              else       state_d    = LOW;
            end
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign uo_out  = sel ? period_q : high_q;
  assign uio_out = {5'b00000, pwm_s, timeout_q, valid_q};
  assign uio_oe  = 8'h07;

endmodule
`default_nettype wire
